// File: rtl/archie_mem_pkg.sv
// Shared types for the Archimedes memory path.
//   arb_state_t : grant state of loader_ram_arb
//   CTI_*       : wishbone cycle-type identifiers used by the core master
//   ldr_req_t   : one buffered loader write (24-bit byte address, data, byte enables)
package archie_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LDR  = 2'd1,
    CORE = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Loader addresses only ever reach 16 MB, so 24 bits are kept per entry
  // and zero-extended to the RAM address width at the output mux.
  typedef struct packed {
    logic [23:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } ldr_req_t;

endpackage

// File: rtl/ldr_fifo.sv
// First-word-fall-through FIFO for loader writes.
// Ports:
//   clk_sys, reset       : clock, async active-high reset (empties the FIFO)
//   push, push_data      : write request; accepted when not full, or when full
//                          and a pop happens in the same cycle
//   pop                  : remove head (ignored when empty)
//   head                 : current head entry (valid while !empty)
//   full, empty          : status
//   fill, fill_nxt       : current occupancy and occupancy after this cycle
module ldr_fifo
  import archie_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  ldr_req_t                 push_data,
  input  logic                     pop,
  output ldr_req_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [$clog2(DEPTH):0]   fill_nxt
);

  localparam int PW = $clog2(DEPTH);

  ldr_req_t    mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fill     = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (fill == (PW+1)'(DEPTH));
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign fill_nxt = fill + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  assign head     = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until the write pointer moves.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/loader_ram_arb.sv
// Merges the HPS ioctl loader and the archimedes_top wishbone master onto the
// single sdram_top wishbone port. Loader writes are buffered in ldr_fifo and
// have priority whenever the arbiter is idle; core bursts are never broken.
// Ports:
//   clk_sys, reset                         : clock, async active-high reset
//   ioctl_wr/addr/dout/sel                 : loader write strobe and payload
//   ioctl_wait                             : back-pressure to hps_io
//   ldr_overflow                           : sticky, a loader write was dropped
//   core_stb/cyc/we/sel/cti/adr/dat        : core wishbone master
//   core_ack                               : ack for the core's own cycles only
//   ram_stb/cyc/we/sel/cti/adr/dat, ram_ack: wishbone port to sdram_top
//
// state | meaning
// IDLE  | no grant; ram strobes low; loader entry wins over a core request
// LDR   | write of the registered FIFO head; pop on ram_ack
// CORE  | core signals passed straight through until last beat acked or cyc drops
module loader_ram_arb
  import archie_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 26
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [31:0]   ioctl_dout,
  input  logic [3:0]    ioctl_sel,
  output logic          ioctl_wait,
  output logic          ldr_overflow,
  input  logic          core_stb,
  input  logic          core_cyc,
  input  logic          core_we,
  input  logic [3:0]    core_sel,
  input  logic [2:0]    core_cti,
  input  logic [26:2]   core_adr,
  input  logic [31:0]   core_dat,
  output logic          core_ack,
  output logic          ram_stb,
  output logic          ram_cyc,
  output logic          ram_we,
  output logic [3:0]    ram_sel,
  output logic [2:0]    ram_cti,
  output logic [AW-1:0] ram_adr,
  output logic [31:0]   ram_dat,
  input  logic          ram_ack
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] FILL_HI = (PW+1)'(DEPTH - 1);

  arb_state_t  state;
  arb_state_t  state_nxt;
  ldr_req_t    ldr_in;
  ldr_req_t    ldr_head;
  ldr_req_t    ldr_q;
  logic        ldr_full;
  logic        ldr_empty;
  logic [PW:0] ldr_fill;
  logic [PW:0] ldr_fill_nxt;
  logic        ldr_load;
  logic        ldr_pop;
  logic        ldr_drop;
  logic        core_last;
  logic        unused_bits;

  assign ldr_in = {ioctl_addr[23:2], 2'b00, ioctl_dout, ioctl_sel};

  // Pop only happens in LDR, where the FIFO is known non-empty, so a full
  // FIFO with a pop frees exactly the slot the push needs.
  assign ldr_drop  = ioctl_wr & ldr_full & ~ldr_pop;
  assign core_last = (core_cti == CTI_CLASSIC) || (core_cti == CTI_EOB);

  assign unused_bits = ^{ioctl_addr[24], ioctl_addr[1:0], core_adr[26:24], ldr_fill};

  ldr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (ioctl_wr),
    .push_data (ldr_in),
    .pop       (ldr_pop),
    .head      (ldr_head),
    .full      (ldr_full),
    .empty     (ldr_empty),
    .fill      (ldr_fill),
    .fill_nxt  (ldr_fill_nxt)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ldr_q        <= '0;
      ioctl_wait   <= 1'b0;
      ldr_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      ioctl_wait <= (ldr_fill_nxt >= FILL_HI);
      if (ldr_load) ldr_q <= ldr_head;
      if (ldr_drop) ldr_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ldr_load  = 1'b0;
    ldr_pop   = 1'b0;
    ram_stb   = 1'b0;
    ram_cyc   = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = '0;
    ram_cti   = CTI_CLASSIC;
    ram_adr   = '0;
    ram_dat   = '0;
    core_ack  = 1'b0;
    case (state)
      IDLE: begin
        // ram_ack is ignored here, so an ack left over from before a reset
        // can neither pop the FIFO nor reach the core.
        if (!ldr_empty) begin
          state_nxt = LDR;
          ldr_load  = 1'b1;
        end else if (core_stb && core_cyc) begin
          state_nxt = CORE;
        end
      end
      LDR: begin
        ram_stb = 1'b1;
        ram_cyc = 1'b1;
        ram_we  = 1'b1;
        ram_sel = ldr_q.sel;
        ram_adr = AW'(ldr_q.adr);
        ram_dat = ldr_q.dat;
        if (ram_ack) begin
          ldr_pop   = 1'b1;
          state_nxt = IDLE;
        end
      end
      CORE: begin
        ram_stb  = core_stb;
        ram_cyc  = core_cyc;
        ram_we   = core_we;
        ram_sel  = core_sel;
        ram_cti  = core_cti;
        ram_adr  = AW'({core_adr[23:2], 2'b00});
        ram_dat  = core_dat;
        core_ack = ram_ack;
        if (!core_cyc || (ram_ack && core_last)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_loader_ram_arb.sv
`timescale 1ns/1ps
module tb_loader_ram_arb;
  import archie_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 26;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [31:0]   ioctl_dout = '0;
  logic [3:0]    ioctl_sel = '0;
  logic          ioctl_wait;
  logic          ldr_overflow;
  logic          core_stb = 1'b0;
  logic          core_cyc = 1'b0;
  logic          core_we = 1'b0;
  logic [3:0]    core_sel = '0;
  logic [2:0]    core_cti = '0;
  logic [26:2]   core_adr = '0;
  logic [31:0]   core_dat = '0;
  logic          core_ack;
  logic          ram_stb;
  logic          ram_cyc;
  logic          ram_we;
  logic [3:0]    ram_sel;
  logic [2:0]    ram_cti;
  logic [AW-1:0] ram_adr;
  logic [31:0]   ram_dat;
  logic          ram_ack = 1'b0;

  loader_ram_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .ioctl_sel    (ioctl_sel),
    .ioctl_wait   (ioctl_wait),
    .ldr_overflow (ldr_overflow),
    .core_stb     (core_stb),
    .core_cyc     (core_cyc),
    .core_we      (core_we),
    .core_sel     (core_sel),
    .core_cti     (core_cti),
    .core_adr     (core_adr),
    .core_dat     (core_dat),
    .core_ack     (core_ack),
    .ram_stb      (ram_stb),
    .ram_cyc      (ram_cyc),
    .ram_we       (ram_we),
    .ram_sel      (ram_sel),
    .ram_cti      (ram_cti),
    .ram_adr      (ram_adr),
    .ram_dat      (ram_dat),
    .ram_ack      (ram_ack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic [2:0]    cti;
    logic          core;
  } beat_t;

  beat_t exp_q[$];
  beat_t got;
  int    n_vec = 0;
  int    n_bad = 0;
  int    n_beats = 0;
  int    n_core_acks = 0;

  bit    ack_en = 1'b0;
  bit    force_ack = 1'b0;
  int    ack_delay = 0;
  int    ack_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [AW-1:0] adr, input logic [31:0] dat,
                                    input logic [3:0] sel, input logic we,
                                    input logic [2:0] cti, input logic core);
    beat_t b;
    b.adr = adr; b.dat = dat; b.sel = sel; b.we = we; b.cti = cti; b.core = core;
    return b;
  endfunction

  // All main-thread drives and checks happen 3 ns after the rising edge.
  task automatic step();
    @(posedge clk_sys);
    #3;
  endtask

  // SDRAM model: acks a strobed beat after ack_delay wait cycles.
  initial forever begin
    @(posedge clk_sys);
    #2;
    ram_ack = force_ack;
    if (ack_en && ram_stb && ram_cyc) begin
      if (ack_cnt >= ack_delay) begin
        ram_ack = 1'b1;
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Scoreboard monitor: every accepted RAM beat is matched against the queue.
  initial forever begin
    @(negedge clk_sys);
    if (ram_stb && ram_cyc && ram_ack) begin
      got = mk_beat(ram_adr, ram_dat, ram_sel, ram_we, ram_cti, core_ack);
      n_beats++;
      if (core_ack) n_core_acks++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0h expected no beat", got);
      end else begin
        chk("ram_beat", got, exp_q.pop_front());
      end
    end else if (core_ack) begin
      n_vec++;
      n_bad++;
      $display("FAIL stray_core_ack: got 1 expected 0 (no accepted ram beat)");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ldr_push(input logic [24:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [AW-1:0] exp_adr, input bit stored);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; ioctl_sel = s;
    if (stored) exp_q.push_back(mk_beat(exp_adr, d, s, 1'b1, CTI_CLASSIC, 1'b0));
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic core_beat(input logic [24:0] w, input logic [31:0] d, input logic we,
                           input logic [2:0] cti, input int budget, input string name);
    bit done = 1'b0;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = we; core_cti = cti;
    core_sel = 4'hF; core_adr = w; core_dat = d;
    for (int k = 0; k < budget && !done; k++) begin
      if (core_ack) done = 1'b1;
      step();
    end
    chk(name, done, 1'b1);
  endtask

  task automatic drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && !ram_stb) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_stb"},  ram_stb, 1'b0);
    chk({tag, "_ram_cyc"},  ram_cyc, 1'b0);
    chk({tag, "_ram_we"},   ram_we, 1'b0);
    chk({tag, "_ram_sel"},  ram_sel, 4'h0);
    chk({tag, "_ram_cti"},  ram_cti, 3'h0);
    chk({tag, "_ram_adr"},  ram_adr, 26'h0);
    chk({tag, "_ram_dat"},  ram_dat, 32'h0);
    chk({tag, "_core_ack"}, core_ack, 1'b0);
    chk({tag, "_wait"},     ioctl_wait, 1'b0);
    chk({tag, "_overflow"}, ldr_overflow, 1'b0);
  endtask

  initial begin
    int base;

    // Reset state
    step();
    step();
    chk_reset_outputs("por");
    reset = 1'b0;
    step();

    // Single loader write: addr bits 24 and 1:0 must be dropped
    ack_en = 1'b1; ack_delay = 3;
    ldr_push(25'h1000107, 32'hDEADBEEF, 4'hF, 26'h0000104, 1'b1);
    chk("single_idle_cycle", ram_stb, 1'b0);
    step();
    chk("single_stb_n2", ram_stb, 1'b1);
    chk("single_we", ram_we, 1'b1);
    chk("single_adr", ram_adr, 26'h0000104);
    drain(20, "single_drain");
    chk("single_wait", ioctl_wait, 1'b0);

    // Back-pressure: 4 back-to-back pushes with ack held off
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h0000010 + 25'(4 * i);
      ioctl_dout = 32'hA000_0000 + 32'(i);
      ioctl_sel = 4'hF;
      exp_q.push_back(mk_beat(26'h0000010 + 26'(4 * i), 32'hA000_0000 + 32'(i), 4'hF,
                              1'b1, CTI_CLASSIC, 1'b0));
      step();
      chk($sformatf("bp_wait_after_push%0d", i + 1), ioctl_wait, (i >= 2) ? 1'b1 : 1'b0);
    end
    ioctl_wr = 1'b0;
    ack_en = 1'b1; ack_delay = 0;
    drain(40, "bp_drain");
    chk("bp_wait_released", ioctl_wait, 1'b0);

    // Overflow: 5 pushes, no ack; the 5th is dropped
    base = n_beats;
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ldr_push(25'h0000800 + 25'(4 * i), 32'h0F0F_0000 + 32'(i), 4'h3,
               26'h0000800 + 26'(4 * i), (i < 4));
      chk($sformatf("ovf_flag_after_push%0d", i + 1), ldr_overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    ack_en = 1'b1; ack_delay = 1;
    drain(60, "ovf_drain");
    repeat (5) step();
    chk("ovf_ram_writes", n_beats - base, 4);

    // Core burst with a loader write arriving at beat 2
    ack_delay = 0;
    base = n_core_acks;
    exp_q.push_back(mk_beat(26'h0002000, 32'hB000_0000, 4'hF, 1'b1, CTI_INCR, 1'b1));
    exp_q.push_back(mk_beat(26'h0002004, 32'hB000_0001, 4'hF, 1'b1, CTI_INCR, 1'b1));
    exp_q.push_back(mk_beat(26'h0002008, 32'hB000_0002, 4'hF, 1'b1, CTI_INCR, 1'b1));
    exp_q.push_back(mk_beat(26'h000200C, 32'hB000_0003, 4'hF, 1'b1, CTI_EOB, 1'b1));
    core_beat(25'h1000800, 32'hB000_0000, 1'b1, CTI_INCR, 20, "burst_beat0");
    core_beat(25'h1000801, 32'hB000_0001, 1'b1, CTI_INCR, 20, "burst_beat1");
    fork
      ldr_push(25'h0000200, 32'h1234_5678, 4'hF, 26'h0000200, 1'b1);
      core_beat(25'h1000802, 32'hB000_0002, 1'b1, CTI_INCR, 20, "burst_beat2");
    join
    core_beat(25'h1000803, 32'hB000_0003, 1'b1, CTI_EOB, 20, "burst_beat3");
    chk("burst_idle_gap", ram_stb, 1'b0);
    core_cyc = 1'b0; core_stb = 1'b0;
    step();
    chk("burst_then_ldr_stb", ram_stb, 1'b1);
    chk("burst_then_ldr_adr", ram_adr, 26'h0000200);
    drain(20, "burst_drain");
    chk("burst_core_acks", n_core_acks - base, 4);

    // Priority: loader entry and core read pending in the same idle cycle
    ack_delay = 2;
    ldr_push(25'h0000300, 32'hCAFE_F00D, 4'h3, 26'h0000300, 1'b1);
    exp_q.push_back(mk_beat(26'h0004000, 32'h5A5A_0000, 4'hF, 1'b0, CTI_CLASSIC, 1'b1));
    core_beat(25'h0001000, 32'h5A5A_0000, 1'b0, CTI_CLASSIC, 30, "prio_core_read");
    core_cyc = 1'b0; core_stb = 1'b0;
    drain(20, "prio_drain");

    // Reset while a loader write is on the bus with a second entry queued
    ack_en = 1'b0;
    ldr_push(25'h0000400, 32'h1111_1111, 4'hF, 26'h0000400, 1'b1);
    ldr_push(25'h0000404, 32'h2222_2222, 4'hF, 26'h0000404, 1'b1);
    chk("rst_stb_before", ram_stb, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("rst_stray_ack_core_ack", core_ack, 1'b0);
    chk("rst_stray_ack_stb", ram_stb, 1'b0);
    base = n_beats;
    repeat (6) step();
    chk("rst_nothing_issued", n_beats - base, 0);
    chk("rst_stb_quiet", ram_stb, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/loader_ram_arb.md
# loader_ram_arb

Wishbone arbiter and loader write buffer that sits directly upstream of `sdram_top`. It merges two request sources into the single SDRAM wishbone port:

- the HPS ioctl loader (ROM/disk image download), which writes 32-bit words;
- the `archimedes_top` memory master, which reads and writes, including bursts.

Loader writes go through a small FIFO, and `ioctl_wait` provides back-pressure to `hps_io`. The core is acked only for its own cycles.

## Interface
Parameters:
- `DEPTH`, 4: loader FIFO entries; power of two, ≥ 2.
- `AW`, 26: RAM byte-address width.

Ports:
- `clk_sys` in 1: system clock (32 MHz domain).
- `reset` in 1: asynchronous, active-high.
- `ioctl_wr` in 1: loader write strobe, 1-cycle pulse.
- `ioctl_addr` in 25: loader byte address.
- `ioctl_dout` in 32: loader write data.
- `ioctl_sel` in 4: loader byte enables.
- `ioctl_wait` out 1: back-pressure to hps_io.
- `ldr_overflow` out 1: sticky flag; a loader write was dropped.
- `core_stb`, `core_cyc`, `core_we` in 1 each: core wishbone master controls.
- `core_sel` in 4: core byte enables.
- `core_cti` in 3: core cycle-type identifier.
- `core_adr` in 25 [26:2]: core word address.
- `core_dat` in 32: core write data.
- `core_ack` out 1: ack to the core.
- `ram_stb`, `ram_cyc`, `ram_we` out 1 each: to sdram_top.
- `ram_sel` out 4: to sdram_top.
- `ram_cti` out 3: to sdram_top.
- `ram_adr` out AW: to sdram_top.
- `ram_dat` out 32: to sdram_top.
- `ram_ack` in 1: from sdram_top.

## Operation
- FIFO push: on `ioctl_wr`, store {`ioctl_addr[23:2]`,`2'b00`} zero-extended to AW, together with data and sel.
- FIFO overflow: a push while full is dropped and sets `ldr_overflow`, which is cleared only by `reset`.
- FIFO push and pop in the same cycle: both are accepted, fill is unchanged (legal even when full).
- Arbiter states: IDLE, LDR, CORE.
- IDLE:
  - if the FIFO is non-empty, go to LDR (loader has priority) and register the FIFO head into the loader output registers;
  - else if `core_stb & core_cyc`, go to CORE;
  - all `ram_*` strobes are low.
- LDR:
  - drive `ram_stb` = `ram_cyc` = `ram_we` = 1 and `ram_cti` = 000, with the registered addr/data/sel;
  - on `ram_ack`: pop the FIFO and go to IDLE.
- CORE:
  - `ram_*` is a combinational pass-through of `core_*`;
  - `ram_adr` = {`core_adr[23:2]`,`2'b00`} zero-extended;
  - `core_ack` = `ram_ack`;
  - leave to IDLE when `ram_ack` arrives with `core_cti` ∈ {000, 111}, or when `core_cyc` drops;
  - a burst (`cti` = 010) holds the grant until its 111 beat is acked.
- `core_ack` is 0 outside CORE. A pending loader entry never interrupts a core burst.
- `ioctl_wait`:
  - registered; asserted when fill after this cycle's push/pop is ≥ DEPTH−1;
  - deasserted when fill ≤ DEPTH−2.
- Reset (asynchronous, may occur mid-operation):
  - FIFO emptied, state IDLE;
  - `ram_stb`/`ram_cyc`/`ram_we` = 0, `ram_sel` = 0, `ram_cti` = 0, `ram_adr` = 0, `ram_dat` = 0;
  - `core_ack` = 0, `ioctl_wait` = 0, `ldr_overflow` = 0;
  - an in-flight ack arriving after reset release in IDLE is ignored.

## Timing
- Loader write latency:
  - `ioctl_wr` at cycle N → entry visible at N+1;
  - IDLE→LDR at N+1 with `ram_stb` high at N+2;
  - pop on the ack cycle;
  - at least one IDLE cycle between any two granted cycles.
- Core single access: `core_stb` seen in IDLE at cycle M → `ram_stb` high from M+1 until ack.
- Core burst: passes through beat-for-beat with no gaps inserted.
- FIFO is first-word-fall-through; pointers are log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH.
- `ram_ack` is assumed single-cycle per beat, as provided by sdram_top.

## Structure
- A shared package `archie_mem_pkg` holds:
  - `arb_state_t` enum (IDLE/LDR/CORE);
  - the CTI constants `CTI_CLASSIC` = 000, `CTI_INCR` = 010, `CTI_EOB` = 111;
  - struct `ldr_req_t` {adr, dat, sel}.
- One sub-module, `ldr_fifo`: parameterised DEPTH, FWFT, outputs fill count and full/empty.
- Arbiter FSM and output muxing live in the top.

## Test plan
- Single loader write:
  - stimulus: `ioctl_wr` with addr 0x000104, data 0xDEADBEEF, sel 1111; ram_ack 3 cycles after stb;
  - response: exactly one ram cycle with adr 0x104, we=1, then FIFO empty and `ioctl_wait` = 0.
- Back-pressure:
  - stimulus: 4 back-to-back `ioctl_wr` with ram_ack held off;
  - response: `ioctl_wait` rises after the 3rd push; the 4th is stored; all 4 retire in order.
- Overflow:
  - stimulus: 5 pushes with no ack;
  - response: 5th dropped, `ldr_overflow` = 1, only 4 RAM writes ever issued.
- Core burst versus loader:
  - stimulus: core 4-beat burst (010,010,010,111) in progress, `ioctl_wr` arrives at beat 2;
  - response: all 4 beats complete with `core_ack` ×4, then one IDLE cycle, then the loader write.
- Priority:
  - stimulus: core_stb and a FIFO entry both pending in IDLE;
  - response: loader granted first; core_ack stays 0 until its own cycle; core read returns afterward.
- Reset mid-LDR:
  - stimulus: assert reset while `ram_stb` = 1 with 2 entries queued;
  - response: all outputs go to their reset values immediately; after release, nothing is issued and a stray ram_ack produces no core_ack.
